handshake_sync_arbiter: RTL and testbench

Source-domain scheduler that shares one handshake_synchronizer sender port among NUM_REQ requesters. It accepts word requests and picks one requester round-robin. It then drives the synchronizer start/data_in/ready handshake: wait ready=1, assert start with data, hold until ready=0, then drop start. The granted requester receives a one-cycle ack. Sits entirely in the src_clk domain, directly in front of the synchronizer.

---
 rtl/handshake_sync_arbiter_pkg.sv | 9 +
 rtl/handshake_sync_arbiter_if.sv | 30 +++
 rtl/handshake_sync_arbiter_rr_priority_picker.sv | 26 ++
 rtl/handshake_sync_arbiter.sv | 81 ++++++++
 tb/tb_handshake_sync_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/handshake_sync_arbiter_pkg.sv
// Shared types and defaults for the handshake synchronizer front-end arbiter.
package handshake_sync_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, RELEASE} state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int ID_WIDTH       = $clog2(DEF_NUM_REQ);
endpackage

// File: rtl/handshake_sync_arbiter_if.sv
// Requester bus plus synchronizer sender port, as seen by the arbiter (master).
interface handshake_sync_arbiter_if
  import handshake_sync_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 ack;
  logic                               sync_start;
  logic [DATA_WIDTH-1:0]              sync_data;
  logic                               sync_ready;
  logic                               busy;
  logic [IDW-1:0]                     grant_id;
  logic [CNT_WIDTH-1:0]               xfer_count;

  modport master (
    input  req, req_data, sync_ready,
    output ack, sync_start, sync_data, busy, grant_id, xfer_count
  );

  modport slave (
    output req, req_data, sync_ready,
    input  ack, sync_start, sync_data, busy, grant_id, xfer_count
  );
endinterface

// File: rtl/handshake_sync_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request scanning upward from i_last+1.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_valid
);
  logic [ID_W-1:0] w_idx;

  // Walk from lowest to highest priority so the closest-after-last hit wins.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_idx = ID_W'((int'(i_last) + i) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
        o_valid  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/handshake_sync_arbiter.sv
// Round-robin scheduler sharing one handshake_synchronizer sender port among NUM_REQ requesters.
module handshake_sync_arbiter
  import handshake_sync_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input logic                    src_clk,
  input logic                    src_reset,
  handshake_sync_arbiter_if.master bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW-1:0]     LAST_ID = IDW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT = NUM_REQ'(1);

  state_t                r_state;
  logic                  r_start;
  logic [DATA_WIDTH-1:0] r_data;
  logic [NUM_REQ-1:0]    r_ack;
  logic                  r_busy;
  logic [IDW-1:0]        r_gid;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic [IDW-1:0]        w_winner;
  logic                  w_valid;

  rr_priority_picker #(.NUM_REQ(NUM_REQ), .ID_W(IDW)) u_pick (
    .i_req    (bus.req),
    .i_last   (r_gid),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  // r_gid resets to the last index so requester 0 wins the first arbitration.
  always_ff @(posedge src_clk or negedge src_reset) begin
    if (!src_reset) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_data  <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_gid   <= LAST_ID;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid && bus.sync_ready) begin
            r_gid   <= w_winner;
            r_data  <= bus.req_data[w_winner];
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          // Synchronizer took the word once it drops ready; no abort path.
          if (!bus.sync_ready) begin
            r_start <= 1'b0;
            r_ack   <= ONE_HOT << r_gid;
            r_cnt   <= r_cnt + CNT_WIDTH'(1);
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          r_ack   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack        = r_ack;
  assign bus.sync_start = r_start;
  assign bus.sync_data  = r_data;
  assign bus.busy       = r_busy;
  assign bus.grant_id   = r_gid;
  assign bus.xfer_count = r_cnt;
endmodule

// File: tb/tb_handshake_sync_arbiter.sv
// Directed bench: vector table for basic/round-robin traffic plus hand sequences for corner cases.
module tb_handshake_sync_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int CW = 4;

  logic src_clk   = 1'b0;
  logic src_reset = 1'b1;
  int   total     = 0;
  int   bad       = 0;

  handshake_sync_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) bus ();

  handshake_sync_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .src_clk   (src_clk),
    .src_reset (src_reset),
    .bus       (bus)
  );

  always #5 src_clk = ~src_clk;

  typedef struct {
    logic                 do_rst;
    logic [NR-1:0]        req_on;
    logic [NR-1:0][DW-1:0] dat;
    int                   exp_id;
    logic [DW-1:0]        exp_data;
    logic [CW-1:0]        exp_cnt;
    logic                 drop;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    bus.req        = '0;
    bus.req_data   = '0;
    bus.sync_ready = 1'b1;
    src_reset      = 1'b0;
    #80;
    chk("rst_start", 32'(bus.sync_start), 32'd0);
    chk("rst_data",  bus.sync_data, 32'd0);
    chk("rst_ack",   32'(bus.ack), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_cnt",   32'(bus.xfer_count), 32'd0);
    chk("rst_gid",   32'(bus.grant_id), 32'(NR - 1));
    @(negedge src_clk);
    src_reset = 1'b1;
  endtask

  task automatic wait_start(output bit ok);
    int n = 0;
    while (bus.sync_start !== 1'b1 && n < 40) begin
      @(negedge src_clk);
      n++;
    end
    ok = (n < 40);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL start_timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  // One full transfer with a modelled synchronizer; early = requester drops req
  // in the first LAUNCH cycle, fast = ready already low on that first cycle.
  task automatic xfer(input int id, input logic [DW-1:0] d, input logic [CW-1:0] cnt,
                      input logic drop, input logic early, input logic fast);
    bit ok;
    wait_start(ok);
    if (!ok) return;
    chk("grant_id", 32'(bus.grant_id), 32'(id));
    chk("sync_data", bus.sync_data, d);
    chk("busy_launch", 32'(bus.busy), 32'd1);
    if (early) begin
      bus.req[id]      = 1'b0;
      bus.req_data[id] = 32'hDEAD_BEEF;
    end
    if (!fast) begin
      @(negedge src_clk);
      chk("start_hold", 32'(bus.sync_start), 32'd1);
      chk("data_hold", bus.sync_data, d);
      chk("ack_early", 32'(bus.ack), 32'd0);
    end
    bus.sync_ready = 1'b0;
    @(negedge src_clk);
    chk("ack_pulse", 32'(bus.ack), 32'(1) << id);
    chk("start_fall", 32'(bus.sync_start), 32'd0);
    chk("xfer_count", 32'(bus.xfer_count), 32'(cnt));
    if (drop) bus.req[id] = 1'b0;
    @(negedge src_clk);
    chk("ack_clear", 32'(bus.ack), 32'd0);
    repeat (2) begin
      @(negedge src_clk);
      chk("no_start_nrdy", 32'(bus.sync_start), 32'd0);
      chk("busy_idle", 32'(bus.busy), 32'd0);
    end
    bus.sync_ready = 1'b1;
  endtask

  initial begin
    bit ok;
    bus.req        = '0;
    bus.req_data   = '0;
    bus.sync_ready = 1'b1;

    tbl[0]  = '{1'b1, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hABAB_CDCD}, 0, 32'hABAB_CDCD, 4'd1, 1'b1};
    tbl[1]  = '{1'b1, 4'b0110, {32'h0, 32'hA5A5_A5A5, 32'h1234_5678, 32'h0}, 1, 32'h1234_5678, 4'd1, 1'b1};
    tbl[2]  = '{1'b0, 4'b0000, '0, 2, 32'hA5A5_A5A5, 4'd2, 1'b1};
    tbl[3]  = '{1'b1, 4'b1111, {32'hA1B2_C3D7, 32'hA1B2_C3D6, 32'hA1B2_C3D5, 32'hA1B2_C3D4},
                0, 32'hA1B2_C3D4, 4'd1, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, '0, 1, 32'hA1B2_C3D5, 4'd2, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, '0, 2, 32'hA1B2_C3D6, 4'd3, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, '0, 3, 32'hA1B2_C3D7, 4'd4, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, '0, 0, 32'hA1B2_C3D4, 4'd5, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, '0, 1, 32'hA1B2_C3D5, 4'd6, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, '0, 2, 32'hA1B2_C3D6, 4'd7, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, '0, 3, 32'hA1B2_C3D7, 4'd8, 1'b0};

    // Single requester, two simultaneous requesters, all four round-robin.
    for (int v = 0; v < 11; v++) begin
      if (tbl[v].do_rst) do_reset();
      for (int j = 0; j < NR; j++) begin
        if (tbl[v].req_on[j]) begin
          bus.req[j]      = 1'b1;
          bus.req_data[j] = tbl[v].dat[j];
        end
      end
      xfer(tbl[v].exp_id, tbl[v].exp_data, tbl[v].exp_cnt, tbl[v].drop, 1'b0, 1'b0);
    end

    // Requester 3 drops req during LAUNCH: latched word still delivered, no regrant.
    do_reset();
    bus.req[3]      = 1'b1;
    bus.req_data[3] = 32'h3C3C_0003;
    xfer(3, 32'h3C3C_0003, 4'd1, 1'b0, 1'b1, 1'b0);
    repeat (5) begin
      @(negedge src_clk);
      chk("no_regrant3", 32'(bus.sync_start), 32'd0);
    end

    // Async reset in LAUNCH, then normal service.
    do_reset();
    bus.req[2]      = 1'b1;
    bus.req_data[2] = 32'h2222_0002;
    wait_start(ok);
    #2 src_reset = 1'b0;
    #1;
    chk("abort_start", 32'(bus.sync_start), 32'd0);
    chk("abort_busy",  32'(bus.busy), 32'd0);
    chk("abort_ack",   32'(bus.ack), 32'd0);
    chk("abort_gid",   32'(bus.grant_id), 32'(NR - 1));
    chk("abort_cnt",   32'(bus.xfer_count), 32'd0);
    @(negedge src_clk);
    chk("abort_noack", 32'(bus.ack), 32'd0);
    src_reset = 1'b1;
    xfer(2, 32'h2222_0002, 4'd1, 1'b1, 1'b0, 1'b0);

    // Counter wrap over 17 transfers; odd ones see ready already low in LAUNCH.
    do_reset();
    bus.req[0]      = 1'b1;
    bus.req_data[0] = 32'h6666_0000;
    for (int i = 1; i <= 17; i++) begin
      xfer(0, 32'h6666_0000, CW'(i), (i == 17), 1'b0, i[0]);
    end
    chk("wrap_final", 32'(bus.xfer_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
